// File: rtl/dma_priority_resolver_if.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver_if
// Bundles the command/request/handshake signals of the DMA priority resolver.
// clk and RESET_n are not part of the bundle.
//
//   command   [7:0]  command register word (D7 DACK pol, D6 DREQ pol,
//                    D4 rotating priority, D2 controller disable)
//   DREQ      [3:0]  raw channel requests
//   mask      [3:0]  per-channel mask, 1 = ignored
//   HLDA             hold acknowledge from the CPU
//   EOP_n            end of process, active low
//   HRQ              hold request to the CPU
//   DACK      [3:0]  channel acknowledge, polarity from command[7]
//   active_ch [1:0]  granted channel index
//   busy             controller owns or is negotiating the bus
//   done             one-cycle completion pulse
//
// modport master : the side driving requests (CPU/peripheral/bench)
// modport slave  : the resolver itself
// -----------------------------------------------------------------------------
interface dma_priority_resolver_if;
    logic [7:0] command;
    logic [3:0] DREQ;
    logic [3:0] mask;
    logic       HLDA;
    logic       EOP_n;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] active_ch;
    logic       busy;
    logic       done;

    modport master (
        output command, DREQ, mask, HLDA, EOP_n,
        input  HRQ, DACK, active_ch, busy, done
    );

    modport slave (
        input  command, DREQ, mask, HLDA, EOP_n,
        output HRQ, DACK, active_ch, busy, done
    );
endinterface

// File: rtl/dma_priority_resolver.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver
// Four-channel DMA request arbiter with CPU hold handshake. Qualifies raw
// requests with polarity, mask and global disable, raises HRQ, and on HLDA
// picks one channel (fixed or rotating priority), holding the grant until EOP_n
// or request withdrawal (normal completion, done pulse) or HLDA loss (abort).
//
// Ports:
//   clk      system clock, all state changes on its rising edge
//   RESET_n  asynchronous active-low reset
//   bus      dma_priority_resolver_if.slave (command, DREQ, mask, HLDA, EOP_n
//            in; HRQ, DACK, active_ch, busy, done out)
// -----------------------------------------------------------------------------
module dma_priority_resolver (
    input  logic                           clk,
    input  logic                           RESET_n,
    dma_priority_resolver_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t     state_q, state_d;
    logic       hrq_q, hrq_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] active_ch_q, active_ch_d;
    logic [1:0] pri_ptr_q, pri_ptr_d;
    logic       done_q, done_d;

    logic [3:0] qreq;
    logic [1:0] winner;

    // First set bit of req searching upward from start, wrapping 3 -> 0.
    function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                               input logic [1:0] start);
        logic [1:0] win;
        logic       found;
        logic [1:0] idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Request qualification: polarity, mask, global disable.
    always_comb begin
        qreq = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            qreq[i] = (bus.command[6] ? bus.DREQ[i] : ~bus.DREQ[i])
                      & ~bus.mask[i] & ~bus.command[2];
        end
    end

    // Fixed mode always searches from channel 0.
    assign winner = pick_winner(qreq, bus.command[4] ? pri_ptr_q : 2'd0);

    // State register
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= S_IDLE;
            hrq_q       <= 1'b0;
            grant_q     <= '0;
            active_ch_q <= '0;
            pri_ptr_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hrq_q       <= hrq_d;
            grant_q     <= grant_d;
            active_ch_q <= active_ch_d;
            pri_ptr_q   <= pri_ptr_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        hrq_d       = hrq_q;
        grant_d     = grant_q;
        active_ch_d = active_ch_q;
        pri_ptr_d   = pri_ptr_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (qreq != '0) begin
                    state_d = S_REQ;
                    hrq_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (qreq == '0) begin
                    state_d = S_IDLE;
                    hrq_d   = 1'b0;
                end else if (bus.HLDA) begin
                    state_d     = S_GRANT;
                    grant_d     = 4'b0001 << winner;
                    active_ch_d = winner;
                end
            end
            S_GRANT: begin
                // Losing HLDA aborts even when EOP_n is asserted on the same edge.
                if (!bus.HLDA) begin
                    state_d = S_IDLE;
                    hrq_d   = 1'b0;
                    grant_d = '0;
                end else if (!bus.EOP_n || !qreq[active_ch_q]) begin
                    state_d = S_RELEASE;
                    hrq_d   = 1'b0;
                    grant_d = '0;
                    done_d  = 1'b1;
                    if (bus.command[4]) begin
                        pri_ptr_d = active_ch_q + 2'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (!bus.HLDA) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.HRQ       = hrq_q;
        bus.DACK      = bus.command[7] ? grant_q : ~grant_q;
        bus.active_ch = active_ch_q;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = done_q;
    end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// -----------------------------------------------------------------------------
// tb_dma_priority_resolver
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dma_priority_resolver;

    logic clk;
    logic RESET_n;
    int   checks;
    int   errors;
    bit   running;

    dma_priority_resolver_if bus ();

    dma_priority_resolver dut (
        .clk     (clk),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_hrq;      // hold requested from CPU
    int m_gch;      // granted channel, -1 when none
    bit m_rel;      // waiting for CPU to drop HLDA after completion
    bit m_done;
    int m_ptr;      // rotating search start

    function automatic bit [3:0] model_qreq();
        bit [3:0] q;
        bit       raw;
        q = 0;
        for (int i = 0; i < 4; i++) begin
            raw  = bus.command[6] ? bus.DREQ[i] : !bus.DREQ[i];
            q[i] = raw && !bus.mask[i] && !bus.command[2];
        end
        return q;
    endfunction

    always @(posedge clk or negedge RESET_n) begin
        bit [3:0] q;
        int       start;
        if (!RESET_n) begin
            m_hrq  = 0;
            m_gch  = -1;
            m_rel  = 0;
            m_done = 0;
            m_ptr  = 0;
        end else begin
            q      = model_qreq();
            m_done = 0;
            if (m_gch >= 0) begin
                if (!bus.HLDA) begin
                    m_gch = -1;
                    m_hrq = 0;
                end else if (!bus.EOP_n || !q[m_gch]) begin
                    if (bus.command[4]) m_ptr = (m_gch + 1) % 4;
                    m_gch  = -1;
                    m_hrq  = 0;
                    m_rel  = 1;
                    m_done = 1;
                end
            end else if (m_rel) begin
                if (!bus.HLDA) m_rel = 0;
            end else if (m_hrq) begin
                if (q == 0) m_hrq = 0;
                else if (bus.HLDA) begin
                    start = bus.command[4] ? m_ptr : 0;
                    for (int k = 3; k >= 0; k--) begin
                        if (q[(start + k) % 4]) m_gch = (start + k) % 4;
                    end
                end
            end else if (q != 0) begin
                m_hrq = 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int g;
        if (running) begin
            g = (m_gch >= 0) ? (1 << m_gch) : 0;
            chk("model_hrq", int'(bus.HRQ), int'(m_hrq));
            chk("model_dack", int'(bus.DACK), bus.command[7] ? g : (~g & 15));
            chk("model_busy", int'(bus.busy), int'(m_hrq || m_gch >= 0 || m_rel));
            chk("model_done", int'(bus.done), int'(m_done));
            chk("model_pri_ptr", int'(dut.pri_ptr_q), m_ptr);
            if (m_gch >= 0) chk("model_active_ch", int'(bus.active_ch), m_gch);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] cmd_tab [8];
        cmd_tab = '{8'hC1, 8'hD1, 8'h01, 8'h11, 8'hC5, 8'h41, 8'h81, 8'hD5};
        checks  = 0;
        errors  = 0;
        RESET_n = 1'b0;
        bus.command = 8'hC1;
        bus.DREQ  = 4'b0000;
        bus.mask  = 4'b0000;
        bus.HLDA  = 1'b0;
        bus.EOP_n = 1'b1;
        running   = 1'b1;

        // Reset values and DACK polarity while in reset
        #1;
        chk("rst_hrq", int'(bus.HRQ), 0);
        chk("rst_dack_hi", int'(bus.DACK), 'h0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        bus.command = 8'h01;
        #1;
        chk("rst_dack_lo", int'(bus.DACK), 'hF);
        bus.command = 8'hC1;
        tick(); tick();
        RESET_n = 1'b1;
        tick();

        // Fixed priority, DREQ 1010 -> channel 1
        bus.DREQ = 4'b1010;
        tick();
        chk("fix_hrq", int'(bus.HRQ), 1);
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("fix_dack", int'(bus.DACK), 'h2);
        chk("fix_ch", int'(bus.active_ch), 1);
        bus.EOP_n = 1'b0;
        tick();
        chk("fix_done", int'(bus.done), 1);
        chk("fix_rel_dack", int'(bus.DACK), 'h0);
        chk("fix_rel_hrq", int'(bus.HRQ), 0);
        bus.EOP_n = 1'b1;
        bus.DREQ  = 4'b0000;
        tick();
        chk("fix_done_once", int'(bus.done), 0);
        chk("fix_rel_hold", int'(bus.busy), 1);
        bus.HLDA = 1'b0;
        tick();
        chk("fix_idle", int'(bus.busy), 0);

        // Rotating: serve channel 2, then all requesting -> channel 3
        bus.command = 8'hD1;
        bus.DREQ = 4'b0100;
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("rot_ch2", int'(bus.active_ch), 2);
        bus.DREQ  = 4'b1111;
        bus.EOP_n = 1'b0;
        tick();
        chk("rot_done", int'(bus.done), 1);
        chk("rot_ptr", int'(dut.pri_ptr_q), 3);
        bus.EOP_n = 1'b1;
        tick();
        chk("rot_done_once", int'(bus.done), 0);
        bus.HLDA = 1'b0;
        tick();
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("rot_ch3", int'(bus.active_ch), 3);
        chk("rot_dack3", int'(bus.DACK), 'h8);
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0000;
        tick();
        tick();

        // Active-low polarity
        bus.command = 8'h01;
        bus.DREQ = 4'b1110;
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("pol_dack", int'(bus.DACK), 'hE);
        chk("pol_ch", int'(bus.active_ch), 0);
        bus.DREQ = 4'b1111;
        tick();
        chk("pol_withdraw_done", int'(bus.done), 1);
        bus.HLDA = 1'b0;
        tick();

        // Withdraw before HLDA, then masked request
        bus.command = 8'hC1;
        bus.DREQ = 4'b0001;
        tick();
        chk("wd_hrq", int'(bus.HRQ), 1);
        bus.DREQ = 4'b0000;
        tick();
        chk("wd_hrq_drop", int'(bus.HRQ), 0);
        chk("wd_done", int'(bus.done), 0);
        chk("wd_dack", int'(bus.DACK), 'h0);
        bus.mask = 4'b0001;
        bus.DREQ = 4'b0001;
        tick(); tick();
        chk("mask_hrq", int'(bus.HRQ), 0);
        bus.mask = 4'b0000;
        bus.DREQ = 4'b0000;
        tick();

        // Abort on channel 3, then async reset mid-grant
        bus.command = 8'hD1;
        bus.DREQ = 4'b1000;
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("ab_ch3", int'(bus.active_ch), 3);
        bus.HLDA = 1'b0;
        tick();
        chk("ab_idle", int'(bus.busy), 0);
        chk("ab_dack", int'(bus.DACK), 'h0);
        chk("ab_done", int'(bus.done), 0);
        chk("ab_ptr", int'(dut.pri_ptr_q), 3);
        tick();
        bus.HLDA = 1'b1;
        tick();
        chk("ar_grant", int'(bus.DACK), 'h8);
        #1 RESET_n = 1'b0;
        #1;
        chk("ar_hrq", int'(bus.HRQ), 0);
        chk("ar_dack", int'(bus.DACK), 'h0);
        chk("ar_busy", int'(bus.busy), 0);
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0000;
        tick();
        chk("ar_ptr", int'(dut.pri_ptr_q), 0);
        RESET_n = 1'b1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (!RESET_n) RESET_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) RESET_n = 1'b0;
            if (!m_hrq && m_gch < 0 && !m_rel && $urandom_range(0, 29) == 0)
                bus.command = cmd_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) bus.DREQ = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)
                bus.mask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (bus.HRQ)
                bus.HLDA = ($urandom_range(0, 11) == 0) ? 1'b0
                         : (bus.HLDA || $urandom_range(0, 2) == 0);
            else
                bus.HLDA = bus.HLDA && ($urandom_range(0, 2) != 0);
            bus.EOP_n = ($urandom_range(0, 9) != 0);
        end

        tick();
        running = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
